// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, funct3 codes and helpers for the load/store unit
//
// Contents:
//   lsu_state_t           FSM states (IDLE, LOAD, RMW, WRITE, RESP)
//   F3_B..F3_HU           RV32I load/store funct3 codes
//   misaligned()          1 when a half/word access has non-zero low address bits
//   is_sub_word()         1 for byte/half accesses (stores of these need read-modify-write)
package lsu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW,
        S_WRITE,
        S_RESP
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsupported codes behave as word accesses but never fault.
    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] lo);
        case (funct3)
            F3_H, F3_HU: return lo[0];
            F3_W:        return (lo != 2'b00);
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic is_sub_word(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU, F3_H, F3_HU: return 1'b1;
            default:                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte/half lane extraction for loads and lane merge for stores
//
// Ports:
//   funct3      in   3   access type (byte, half, word; unknown codes = word)
//   offset      in   2   address low bits; half accesses only look at offset[1]
//   word_in     in   32  word read from memory
//   store_data  in   32  store data (low byte/half used for sub-word stores)
//   load_out    out  32  extracted lane, sign- or zero-extended
//   merged_out  out  32  word_in with the addressed lane replaced by store data
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word_in,
    input  logic [31:0] store_data,
    output logic [31:0] load_out,
    output logic [31:0] merged_out
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [31:0] byte_word;
    logic [31:0] half_word;

    // Half accesses ignore offset[0]; a misaligned half collapses onto its aligned lane.
    assign byte_sh   = {offset, 3'b000};
    assign half_sh   = {offset[1], 4'b0000};
    assign byte_word = word_in >> byte_sh;
    assign half_word = word_in >> half_sh;

    always_comb begin
        load_out   = word_in;
        merged_out = store_data;
        case (funct3)
            F3_B: begin
                load_out   = {{24{byte_word[7]}}, byte_word[7:0]};
                merged_out = (word_in & ~(32'h0000_00FF << byte_sh))
                           | ({24'b0, store_data[7:0]} << byte_sh);
            end
            F3_BU: begin
                load_out   = {24'b0, byte_word[7:0]};
                merged_out = (word_in & ~(32'h0000_00FF << byte_sh))
                           | ({24'b0, store_data[7:0]} << byte_sh);
            end
            F3_H: begin
                load_out   = {{16{half_word[15]}}, half_word[15:0]};
                merged_out = (word_in & ~(32'h0000_FFFF << half_sh))
                           | ({16'b0, store_data[15:0]} << half_sh);
            end
            F3_HU: begin
                load_out   = {16'b0, half_word[15:0]};
                merged_out = (word_in & ~(32'h0000_FFFF << half_sh))
                           | ({16'b0, store_data[15:0]} << half_sh);
            end
            default: begin
                load_out   = word_in;
                merged_out = store_data;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory initiator: aligned loads/stores with RMW byte/half stores
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned half/word -> resp_err, no memory access).
// Without it misaligned low bits are ignored and the access proceeds on the aligned lane/word.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake (ready only in IDLE)
//   req_we, req_funct3, req_addr,
//   req_wdata                       request: store flag, RV32I size code, byte address, store data
//   resp_valid                      one-cycle completion pulse
//   resp_rdata, resp_err            load result (0 for stores), misalign error; held until next request
//   mem_addr, mem_we, mem_wdata     word-aligned memory address, write strobe, write word
//   mem_rdata                       combinational read data for mem_addr
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int N = 32,
    parameter int A = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [2:0]   req_funct3,
    input  logic [A-1:0] req_addr,
    input  logic [N-1:0] req_wdata,
    output logic         resp_valid,
    output logic [N-1:0] resp_rdata,
    output logic         resp_err,
    output logic [A-1:0] mem_addr,
    output logic         mem_we,
    output logic [N-1:0] mem_wdata,
    input  logic [N-1:0] mem_rdata
);

    lsu_state_t   state;
    logic [2:0]   r_funct3;
    logic [A-1:0] r_addr;
    logic [N-1:0] r_wdata;
    logic [N-1:0] wbuf;
    logic [N-1:0] load_out;
    logic [N-1:0] merged_out;
    logic         trap;

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = misaligned(req_funct3, req_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    assign req_ready = (state == S_IDLE);
    assign mem_addr  = {r_addr[A-1:2], 2'b00};
    assign mem_wdata = wbuf;

    lsu_align u_align (
        .funct3     (r_funct3),
        .offset     (r_addr[1:0]),
        .word_in    (mem_rdata),
        .store_data (r_wdata),
        .load_out   (load_out),
        .merged_out (merged_out)
    );

    // mem_we and resp_valid are registered one-cycle pulses set on entry to WRITE/RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            r_funct3   <= 3'b000;
            r_addr     <= '0;
            r_wdata    <= '0;
            wbuf       <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_we     <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            mem_we     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_funct3   <= req_funct3;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                        if (trap) begin
                            resp_err   <= 1'b1;
                            resp_valid <= 1'b1;
                            state      <= S_RESP;
                        end else if (!req_we) begin
                            state <= S_LOAD;
                        end else if (is_sub_word(req_funct3)) begin
                            state <= S_RMW;
                        end else begin
                            wbuf   <= req_wdata;
                            mem_we <= 1'b1;
                            state  <= S_WRITE;
                        end
                    end
                end
                S_LOAD: begin
                    resp_rdata <= load_out;
                    resp_valid <= 1'b1;
                    state      <= S_RESP;
                end
                S_RMW: begin
                    wbuf   <= merged_out;
                    mem_we <= 1'b1;
                    state  <= S_WRITE;
                end
                S_WRITE: begin
                    resp_valid <= 1'b1;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized and directed self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [9:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [9:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    // Environment memory (word wide, no byte enables).
    logic [31:0] mem [256];
    // Reference: flat byte-addressable memory, little-endian.
    logic [7:0]  ref_b [1024];

    load_store_unit #(.N(32), .A(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int m_size(input logic [2:0] f);
        if (f == 3'd0 || f == 3'd4) return 1;
        if (f == 3'd1 || f == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic m_trap(input logic [2:0] f, input logic [9:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((f == 3'd1 || f == 3'd5) && a[0]) return 1'b1;
        if (f == 3'd2 && a[1:0] != 2'b00) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic int m_base(input logic [2:0] f, input logic [9:0] a);
        int s = m_size(f);
        return int'(a) - (int'(a) % s);
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f, input logic [9:0] a);
        int b = m_base(f, a);
        logic [31:0] v = 0;
        for (int i = 0; i < m_size(f); i++) v[8*i +: 8] = ref_b[b + i];
        case (f)
            3'd0: v = {{24{v[7]}}, v[7:0]};
            3'd1: v = {{16{v[15]}}, v[15:0]};
            default: ;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] ref_word(input logic [9:0] a);
        int b = int'(a) & ~3;
        return {ref_b[b+3], ref_b[b+2], ref_b[b+1], ref_b[b]};
    endfunction

    // One complete request; all expectations come from the byte-level model.
    task automatic run_req(input logic we, input logic [2:0] f, input logic [9:0] a,
                           input logic [31:0] d, output logic [31:0] rd);
        int lat = 0;
        int we_cnt = 0;
        int exp_lat;
        logic tr = m_trap(f, a);
        logic [31:0] exp_rd;
        logic e = 1'b0;
        exp_rd  = (!we && !tr) ? m_load(f, a) : 32'h0;
        exp_lat = tr ? 1 : (!we ? 2 : (m_size(f) == 4 ? 2 : 3));
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f; req_addr = a; req_wdata = d;
        check("ready_idle", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        rd = 32'h0;
        for (int k = 1; k <= 8; k++) begin
            if (mem_we) begin
                we_cnt++;
                check("mem_addr", {22'b0, mem_addr}, {22'b0, a[9:2], 2'b00});
            end
            if (resp_valid) begin
                lat = k; rd = resp_rdata; e = resp_err;
                break;
            end
            if (req_ready) check("busy_ready", 32'd1, 32'd0);
            @(negedge clk);
        end
        if (!tr && we) begin
            for (int i = 0; i < m_size(f); i++) ref_b[m_base(f, a) + i] = d[8*i +: 8];
        end
        check("latency", lat, exp_lat);
        check("rdata", rd, exp_rd);
        check("err", {31'b0, e}, {31'b0, tr});
        check("we_cnt", we_cnt, (we && !tr) ? 1 : 0);
        @(negedge clk);
        check("held_rdata", resp_rdata, exp_rd);
        if (we) check("mem_word", mem[a[9:2]], ref_word(a));
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] w;
        int lat;
        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            mem[i] = w;
            for (int j = 0; j < 4; j++) ref_b[4*i + j] = w[8*j +: 8];
        end

        // Reset state
        #12;
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_mem_addr", {22'b0, mem_addr}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", {31'b0, resp_err}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // 1: SW / LW
        run_req(1'b1, 3'b010, 10'h010, 32'hDEADBEEF, rd);
        run_req(1'b0, 3'b010, 10'h010, 32'h0, rd);
        check("t1_lw", rd, 32'hDEADBEEF);
        // 2: SB into 0x11223344
        run_req(1'b1, 3'b010, 10'h010, 32'h11223344, rd);
        run_req(1'b1, 3'b000, 10'h013, 32'h000000A5, rd);
        run_req(1'b0, 3'b010, 10'h010, 32'h0, rd);
        check("t2_word", rd, 32'hA5223344);
        run_req(1'b0, 3'b000, 10'h013, 32'h0, rd);
        check("t2_lb", rd, 32'hFFFFFFA5);
        run_req(1'b0, 3'b100, 10'h013, 32'h0, rd);
        check("t2_lbu", rd, 32'h000000A5);
        // 3: SH
        run_req(1'b1, 3'b010, 10'h010, 32'h11223344, rd);
        run_req(1'b1, 3'b001, 10'h012, 32'h00008001, rd);
        run_req(1'b0, 3'b010, 10'h010, 32'h0, rd);
        check("t3_word", rd, 32'h80013344);
        run_req(1'b0, 3'b001, 10'h012, 32'h0, rd);
        check("t3_lh", rd, 32'hFFFF8001);
        run_req(1'b0, 3'b101, 10'h012, 32'h0, rd);
        check("t3_lhu", rd, 32'h00008001);
        // 4: misaligned LW (model decides trap vs word result)
        run_req(1'b0, 3'b010, 10'h011, 32'h0, rd);

        // 5: reset during WRITE
        w = mem[8'h04];
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 10'h010; req_wdata = 32'hCAFEF00D;
        @(negedge clk);
        req_valid = 1'b0;
        check("t5_we_before", {31'b0, mem_we}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_we_async", {31'b0, mem_we}, 32'd0);
        check("t5_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk); rst_n = 1'b1;
        lat = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (resp_valid) lat++;
        end
        check("t5_no_resp", lat, 0);
        check("t5_mem", mem[8'h04], w);
        check("t5_mem_ref", mem[8'h04], ref_word(10'h010));

        // 6: req_valid held across busy SB; second request (LW) accepted at T+4
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 10'h021; req_wdata = 32'h0000003C;
        @(negedge clk);
        ref_b[10'h021] = 8'h3C;
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 10'h020;
        for (int k = 1; k <= 3; k++) begin
            check("t6_busy", {31'b0, req_ready}, 32'd0);
            if (k == 3) check("t6_resp1", {31'b0, resp_valid}, 32'd1);
            @(negedge clk);
        end
        check("t6_ready_t4", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("t6_resp2", {31'b0, resp_valid}, 32'd1);
        check("t6_rdata", resp_rdata, ref_word(10'h020));

        // Randomized traffic over a small region to force lane collisions
        for (int n = 0; n < 150; n++) begin
            run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    10'($urandom_range(0, 63)), $urandom, rd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
